// File: rtl/video_timing_gen.sv
// Raster timing generator: hCount/vCount, syncs and line/frame strobes from shadowed runtime timing.
// Optional VTG_FRAME_COUNT_EN adds a 16-bit frameCount output.
module video_timing_gen #(
  parameter int busWidth = 11
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                enable,
  input  logic [busWidth-1:0] resHorizontal,
  input  logic [busWidth-1:0] hFrontPorch,
  input  logic [busWidth-1:0] hSyncWidth,
  input  logic [busWidth-1:0] hBackPorch,
  input  logic [busWidth-1:0] resVertical,
  input  logic [busWidth-1:0] vFrontPorch,
  input  logic [busWidth-1:0] vSyncWidth,
  input  logic [busWidth-1:0] vBackPorch,
  input  logic                hSyncPol,
  input  logic                vSyncPol,
  output logic [busWidth-1:0] hCount,
  output logic [busWidth-1:0] vCount,
  output logic                hSync,
  output logic                vSync,
  output logic                lineStart,
  output logic                frameStart,
  output logic                configError
`ifdef VTG_FRAME_COUNT_EN
  ,
  output logic [15:0]         frameCount
`endif
);
  localparam int TW = busWidth + 2;
  localparam logic [TW-1:0] MaxTot = TW'(1 << busWidth);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  typedef struct packed {
    logic [busWidth-1:0] hRes, hFp, hSw, hBp, vRes, vFp, vSw, vBp;
    logic hPol, vPol;
  } cfg_t;

  state_t              state, nState;
  cfg_t                shadow, live, nCfg;
  logic [TW-1:0]       hTot, vTot, liveHTot, liveVTot;
  logic [TW-1:0]       nHStart, nHEnd, nVStart, nVEnd;
  logic                liveValid, capture, lastH, lastV;
  logic                hAct, vAct, nHAct, nVAct, nLine, nFrame;
  logic                hPolEff, vPolEff;
  logic [busWidth-1:0] nH, nV;

  function automatic logic [TW-1:0] ext(input logic [busWidth-1:0] x);
    return {2'b00, x};
  endfunction

  assign live = '{hRes: resHorizontal, hFp: hFrontPorch, hSw: hSyncWidth, hBp: hBackPorch,
                  vRes: resVertical, vFp: vFrontPorch, vSw: vSyncWidth, vBp: vBackPorch,
                  hPol: hSyncPol, vPol: vSyncPol};

  assign hTot     = ext(shadow.hRes) + ext(shadow.hFp) + ext(shadow.hSw) + ext(shadow.hBp);
  assign vTot     = ext(shadow.vRes) + ext(shadow.vFp) + ext(shadow.vSw) + ext(shadow.vBp);
  assign liveHTot = ext(live.hRes) + ext(live.hFp) + ext(live.hSw) + ext(live.hBp);
  assign liveVTot = ext(live.vRes) + ext(live.vFp) + ext(live.vSw) + ext(live.vBp);
  assign liveValid = (liveHTot <= MaxTot) && (liveVTot <= MaxTot) &&
                     (liveHTot >= TW'(2)) && (liveVTot >= TW'(1));

  assign lastH = (ext(hCount) == hTot - TW'(1));
  assign lastV = (ext(vCount) == vTot - TW'(1));

  always_ff @(posedge clock or negedge resetN)
    if (!resetN) state <= IDLE;
    else         state <= nState;

  // Next raster position and the config that will govern it; outputs are
  // then registered from these so syncs/strobes line up with the counters.
  always_comb begin
    nState  = state;
    capture = 1'b0;
    nH      = '0;
    nV      = '0;
    case (state)
      IDLE: capture = enable;
      ERR:  capture = 1'b1;
      RUN: begin
        if (lastH) begin
          if (lastV) capture = 1'b1;
          else       nV = vCount + 1'b1;
        end else begin
          nH = hCount + 1'b1;
          nV = vCount;
        end
      end
      default: nState = IDLE;
    endcase
    if (capture) nState = liveValid ? RUN : ERR;
    if (!enable) begin
      nState  = IDLE;
      capture = 1'b0;
    end
    nCfg = capture ? live : shadow;
    if (nState != RUN) begin
      nH = '0;
      nV = '0;
    end
    nLine  = (nState == RUN) && (nH == '0);
    nFrame = nLine && (nV == '0);
  end

  assign nHStart = ext(nCfg.hRes) + ext(nCfg.hFp);
  assign nHEnd   = nHStart + ext(nCfg.hSw);
  assign nVStart = ext(nCfg.vRes) + ext(nCfg.vFp);
  assign nVEnd   = nVStart + ext(nCfg.vSw);
  assign nHAct   = (nState == RUN) && (ext(nH) >= nHStart) && (ext(nH) < nHEnd);
  assign nVAct   = (nState == RUN) && (ext(nV) >= nVStart) && (ext(nV) < nVEnd);

  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      shadow      <= '0;
      hCount      <= '0;
      vCount      <= '0;
      hAct        <= 1'b0;
      vAct        <= 1'b0;
      lineStart   <= 1'b0;
      frameStart  <= 1'b0;
      configError <= 1'b0;
    end else begin
      if (capture) shadow <= live;
      hCount      <= nH;
      vCount      <= nV;
      hAct        <= nHAct;
      vAct        <= nVAct;
      lineStart   <= nLine;
      frameStart  <= nFrame;
      configError <= (nState == ERR);
    end

  // Idle has no captured polarity yet, so inactive level follows the live input.
  assign hPolEff = (state == IDLE) ? hSyncPol : shadow.hPol;
  assign vPolEff = (state == IDLE) ? vSyncPol : shadow.vPol;
  assign hSync   = hAct ? hPolEff : ~hPolEff;
  assign vSync   = vAct ? vPolEff : ~vPolEff;

`ifdef VTG_FRAME_COUNT_EN
  logic wrap;
  assign wrap = (state == RUN) && enable && lastH && lastV;

  always_ff @(posedge clock or negedge resetN)
    if (!resetN)      frameCount <= '0;
    else if (!enable) frameCount <= '0;
    else if (wrap)    frameCount <= frameCount + 16'd1;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a pixel-index raster model queues expected outputs per clock.
module tb_video_timing_gen;
  localparam int BW = 11;

  logic          clock = 1'b0, resetN = 1'b0, enable = 1'b0;
  logic [BW-1:0] resHorizontal, hFrontPorch, hSyncWidth, hBackPorch;
  logic [BW-1:0] resVertical, vFrontPorch, vSyncWidth, vBackPorch;
  logic          hSyncPol, vSyncPol;
  logic [BW-1:0] hCount, vCount;
  logic          hSync, vSync, lineStart, frameStart, configError;
`ifdef VTG_FRAME_COUNT_EN
  logic [15:0]   frameCount;
`endif

  video_timing_gen #(.busWidth(BW)) dut (
    .clock(clock), .resetN(resetN), .enable(enable),
    .resHorizontal(resHorizontal), .hFrontPorch(hFrontPorch), .hSyncWidth(hSyncWidth),
    .hBackPorch(hBackPorch), .resVertical(resVertical), .vFrontPorch(vFrontPorch),
    .vSyncWidth(vSyncWidth), .vBackPorch(vBackPorch), .hSyncPol(hSyncPol), .vSyncPol(vSyncPol),
    .hCount(hCount), .vCount(vCount), .hSync(hSync), .vSync(vSync),
    .lineStart(lineStart), .frameStart(frameStart), .configError(configError)
`ifdef VTG_FRAME_COUNT_EN
    , .frameCount(frameCount)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [BW-1:0] h, v;
    logic hs, vs, ls, fs, err;
    logic [15:0] fc;
  } obs_t;
  typedef struct {
    int  hr, hf, hw, hb, vr, vf, vw, vb;
    bit  hp, vp;
  } cfg_t;

  obs_t expQ[$];
  int   compared = 0, mismatched = 0;

  // Model: mode 0 = off, 1 = bad config, 2 = running; mPix = pixel index within frame.
  int   mMode = 0, mPix = 0;
  cfg_t mCfg;
  int   mFrames = 0;

  function automatic cfg_t liveCfg();
    cfg_t c;
    c.hr = int'(resHorizontal); c.hf = int'(hFrontPorch); c.hw = int'(hSyncWidth); c.hb = int'(hBackPorch);
    c.vr = int'(resVertical);   c.vf = int'(vFrontPorch); c.vw = int'(vSyncWidth); c.vb = int'(vBackPorch);
    c.hp = hSyncPol; c.vp = vSyncPol;
    return c;
  endfunction

  function automatic int hTotOf(cfg_t c); return c.hr + c.hf + c.hw + c.hb; endfunction
  function automatic int vTotOf(cfg_t c); return c.vr + c.vf + c.vw + c.vb; endfunction
  function automatic bit okCfg(cfg_t c);
    return hTotOf(c) <= 2048 && vTotOf(c) <= 2048 && hTotOf(c) >= 2 && vTotOf(c) >= 1;
  endfunction

  // Expected outputs after the coming clock edge, given the inputs now applied.
  task automatic modelStep();
    obs_t e;
    cfg_t c;
    int   ht, h, v;
    c = liveCfg();
    e = '0;
    if (!enable) begin
      mMode = 0; mFrames = 0;
      e.hs = !hSyncPol; e.vs = !vSyncPol;
    end else begin
      if (mMode == 2 && mPix == hTotOf(mCfg) * vTotOf(mCfg) - 1) mFrames = (mFrames + 1) % 65536;
      if (mMode != 2 || mPix == hTotOf(mCfg) * vTotOf(mCfg) - 1) begin
        mCfg = c;
        if (okCfg(c)) begin mMode = 2; mPix = 0; end
        else mMode = 1;
      end else mPix++;
      if (mMode == 1) begin
        e.err = 1'b1; e.hs = !mCfg.hp; e.vs = !mCfg.vp;
      end else begin
        ht = hTotOf(mCfg);
        h = mPix % ht; v = mPix / ht;
        e.h = BW'(h); e.v = BW'(v);
        e.hs = (h >= mCfg.hr + mCfg.hf && h < mCfg.hr + mCfg.hf + mCfg.hw) ? mCfg.hp : !mCfg.hp;
        e.vs = (v >= mCfg.vr + mCfg.vf && v < mCfg.vr + mCfg.vf + mCfg.vw) ? mCfg.vp : !mCfg.vp;
        e.ls = (h == 0); e.fs = (mPix == 0);
      end
    end
    e.fc = 16'(mFrames);
    expQ.push_back(e);
  endtask

  task automatic cyc();
    modelStep();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic setCfg(input int hr, hf, hw, hb, vr, vf, vw, vb, input bit hp, vp);
    resHorizontal = BW'(hr); hFrontPorch = BW'(hf); hSyncWidth = BW'(hw); hBackPorch = BW'(hb);
    resVertical = BW'(vr); vFrontPorch = BW'(vf); vSyncWidth = BW'(vw); vBackPorch = BW'(vb);
    hSyncPol = hp; vSyncPol = vp;
  endtask

  task automatic randH();
    resHorizontal = BW'($urandom_range(0, 10)); hFrontPorch = BW'($urandom_range(0, 3));
    hSyncWidth = BW'($urandom_range(0, 3));     hBackPorch = BW'($urandom_range(0, 3));
  endtask

  task automatic randV();
    resVertical = BW'($urandom_range(0, 6)); vFrontPorch = BW'($urandom_range(0, 2));
    vSyncWidth = BW'($urandom_range(0, 2));  vBackPorch = BW'($urandom_range(0, 2));
  endtask

  // Monitor: every cycle the DUT presents a raster sample; compare against the queue head.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        a = '0;
        a.h = hCount; a.v = vCount; a.hs = hSync; a.vs = vSync;
        a.ls = lineStart; a.fs = frameStart; a.err = configError;
`ifdef VTG_FRAME_COUNT_EN
        a.fc = frameCount;
`else
        a.fc = e.fc;
`endif
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL raster actual h=%0d v=%0d hs=%0b vs=%0b ls=%0b fs=%0b err=%0b fc=%0d expected h=%0d v=%0d hs=%0b vs=%0b ls=%0b fs=%0b err=%0b fc=%0d",
                   a.h, a.v, a.hs, a.vs, a.ls, a.fs, a.err, a.fc, e.h, e.v, e.hs, e.vs, e.ls, e.fs, e.err, e.fc);
        end
      end
    end
  end

  initial begin
    int n, r, guard;
    setCfg(8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b1);
    #3;
    chk("rst_hCount", 32'(hCount), 32'd0);
    chk("rst_vCount", 32'(vCount), 32'd0);
    chk("rst_strobes", {30'd0, lineStart, frameStart}, 32'd0);
    chk("rst_configError", 32'(configError), 32'd0);
    chk("rst_syncs_pol1", {30'd0, hSync, vSync}, 32'd0);
    hSyncPol = 1'b0; vSyncPol = 1'b0;
    #1;
    chk("rst_syncs_pol0", {30'd0, hSync, vSync}, 32'd3);
    hSyncPol = 1'b1; vSyncPol = 1'b1;

    @(posedge clock); #2;
    resetN = 1'b1; enable = 1'b1;
    repeat (2 * 98 + 5) cyc();

    // polarity flip mid-frame takes effect at the next frame boundary
    hSyncPol = 1'b0; vSyncPol = 1'b0;
    repeat (2 * 98) cyc();

    // shrink line length at vCount=2 of a fresh frame
    guard = 0;
    while (!(mMode == 2 && mPix == 2 * 14) && guard < 500) begin cyc(); guard++; end
    chk("reach_v2", 32'(guard < 500), 32'd1);
    resHorizontal = BW'(6);
    repeat (98 - 28 + 2 * 84) cyc();

    // enable drop mid-frame
    repeat (20) cyc();
    enable = 1'b0;
    repeat (3) cyc();
    enable = 1'b1;

    // oversized line -> error, then a legal 2047-pixel line
    setCfg(2047, 1, 3, 1, 4, 1, 1, 1, 1'b1, 1'b1);
    repeat (6) cyc();
    setCfg(2047, 0, 0, 0, 4, 1, 1, 1, 1'b1, 1'b1);
    repeat (2100) cyc();
    enable = 1'b0;
    cyc();

    // async reset at hCount=7, vCount=3
    setCfg(8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b1);
    enable = 1'b1;
    guard = 0;
    while (!(mMode == 2 && mPix == 3 * 14 + 7) && guard < 500) begin cyc(); guard++; end
    chk("reach_h7v3", 32'(guard < 500), 32'd1);
    resetN = 1'b0;
    #1;
    chk("async_rst_counts", {5'd0, hCount, 5'd0, vCount}, 32'd0);
    chk("async_rst_flags", {28'd0, lineStart, frameStart, hSync, vSync}, 32'd0);
    mMode = 0; mFrames = 0;
    #1;
    resetN = 1'b1;
    repeat (3 * 98 + 3) cyc();

    // randomized configs with occasional mid-frame perturbation
    for (int it = 0; it < 25; it++) begin
      randH(); randV();
      hSyncPol = 1'($urandom_range(0, 1)); vSyncPol = 1'($urandom_range(0, 1));
      enable = 1'b1;
      n = $urandom_range(100, 500);
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 99);
        if (r < 2) randH();
        else if (r < 4) randV();
        else if (r == 4) hSyncPol = ~hSyncPol;
        else if (r == 5) enable = 1'b0;
        else enable = 1'b1;
        cyc();
      end
    end

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clock);
    #2;
    chk("queue_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
